// File: rtl/spi_flash_arbiter_if.sv
// Bundle of every signal between the two SPI masters, the flash and the arbiter.
//   REQ0/REQ1       level bus requests from the two masters
//   GNT0/GNT1       registered grants, one-hot or zero
//   nCS0/1, CLK0/1, MOSI0/1   requester-side SPI outputs
//   MISO0/MISO1     flash data routed back to the grantee
//   nCS, CLK, MOSI  flash-side SPI inputs, MISO flash-side data out
//   BUSY, TIMEOUT_ERR, ERR_ID status
// Modport slave is the arbiter's view; modport master is the requester/flash side.
interface spi_flash_arbiter_if;
  logic REQ0;
  logic REQ1;
  logic GNT0;
  logic GNT1;
  logic nCS0;
  logic nCS1;
  logic CLK0;
  logic CLK1;
  logic MOSI0;
  logic MOSI1;
  logic MISO0;
  logic MISO1;
  logic nCS;
  logic CLK;
  logic MOSI;
  logic MISO;
  logic BUSY;
  logic TIMEOUT_ERR;
  logic ERR_ID;

  modport slave (
    input  REQ0, REQ1, nCS0, nCS1, CLK0, CLK1, MOSI0, MOSI1, MISO,
    output GNT0, GNT1, MISO0, MISO1, nCS, CLK, MOSI, BUSY, TIMEOUT_ERR, ERR_ID
  );

  modport master (
    output REQ0, REQ1, nCS0, nCS1, CLK0, CLK1, MOSI0, MOSI1, MISO,
    input  GNT0, GNT1, MISO0, MISO1, nCS, CLK, MOSI, BUSY, TIMEOUT_ERR, ERR_ID
  );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Shares one W25Q32 SPI flash bus between two SPI masters.
// Requester 0 (page/boot loader) has priority; requester 1 (directory/config
// reader) is protected from starvation. A minimum nCS-high gap separates
// grants and a watchdog breaks grants that last too long.
// Ports:
//   MCLK    clock, all logic on posedge
//   nRESET  asynchronous active-low reset
//   bus     spi_flash_arbiter_if.slave: requests/grants, both requester SPI
//           ports, the flash SPI port and status (BUSY, TIMEOUT_ERR, ERR_ID)
module spi_flash_arbiter #(
  parameter int CS_GAP       = 4,
  parameter int STARVE_LIMIT = 4096,
  parameter int TMR_W        = 20,
  parameter int TIMEOUT_CYC  = 1000000
) (
  input  logic                  MCLK,
  input  logic                  nRESET,
  spi_flash_arbiter_if.slave    bus
);

  localparam int               GAP_W      = (CS_GAP > 1) ? $clog2(CS_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(CS_GAP - 1);
  localparam logic [TMR_W-1:0] STARVE_LIM = TMR_W'(STARVE_LIMIT);
  localparam logic [TMR_W-1:0] WD_LAST    = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             gnt0_r;
  logic             gnt1_r;
  logic             busy_r;
  logic             tmo_r;
  logic             err_id_r;
  logic             mask0_r;
  logic             mask1_r;
  logic [TMR_W-1:0] wd_cnt_r;
  logic [TMR_W-1:0] starve_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;

  logic             elig0_s;
  logic             elig1_s;
  logic             starved_s;
  logic             wd_fire_s;
  logic             gap_done_s;
  logic             rel0_s;
  logic             rel1_s;
  logic             tmo_s;
  logic             tmo_id_s;

  assign elig0_s    = bus.REQ0 & ~mask0_r;
  assign elig1_s    = bus.REQ1 & ~mask1_r;
  assign starved_s  = (starve_cnt_r >= STARVE_LIM);
  assign wd_fire_s  = (wd_cnt_r == WD_LAST);
  assign gap_done_s = (gap_cnt_r == GAP_LAST);
  // A dropped request only releases once the master has also raised its nCS.
  assign rel0_s     = ~bus.REQ0 & bus.nCS0;
  assign rel1_s     = ~bus.REQ1 & bus.nCS1;

  // Next-state and timeout-event decode.
  always_comb begin
    state_nxt_s = state_r;
    tmo_s       = 1'b0;
    tmo_id_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (elig1_s && starved_s) begin
          state_nxt_s = ST_GRANT1;
        end else if (elig0_s) begin
          state_nxt_s = ST_GRANT0;
        end else if (elig1_s) begin
          state_nxt_s = ST_GRANT1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT0: begin
        // Normal release wins over a watchdog expiry on the same cycle.
        if (rel0_s) begin
          state_nxt_s = ST_GAP;
        end else if (wd_fire_s) begin
          state_nxt_s = ST_GAP;
          tmo_s       = 1'b1;
          tmo_id_s    = 1'b0;
        end else begin
          state_nxt_s = ST_GRANT0;
        end
      end
      ST_GRANT1: begin
        if (rel1_s) begin
          state_nxt_s = ST_GAP;
        end else if (wd_fire_s) begin
          state_nxt_s = ST_GAP;
          tmo_s       = 1'b1;
          tmo_id_s    = 1'b1;
        end else begin
          state_nxt_s = ST_GRANT1;
        end
      end
      ST_GAP: begin
        if (gap_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register plus registered grant/status outputs derived from next state.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_r  <= ST_IDLE;
      gnt0_r   <= 1'b0;
      gnt1_r   <= 1'b0;
      busy_r   <= 1'b0;
      tmo_r    <= 1'b0;
      err_id_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      gnt0_r   <= (state_nxt_s == ST_GRANT0);
      gnt1_r   <= (state_nxt_s == ST_GRANT1);
      busy_r   <= (state_nxt_s != ST_IDLE);
      tmo_r    <= tmo_s;
      if (tmo_s) begin
        err_id_r <= tmo_id_s;
      end
    end
  end

  // Watchdog and gap counters; both restart from zero on entry to their state.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      wd_cnt_r  <= '0;
      gap_cnt_r <= '0;
    end else begin
      if ((state_r == ST_GRANT0) || (state_r == ST_GRANT1)) begin
        wd_cnt_r <= wd_cnt_r + {{(TMR_W-1){1'b0}}, 1'b1};
      end else begin
        wd_cnt_r <= '0;
      end
      if (state_r == ST_GAP) begin
        gap_cnt_r <= gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
      end else begin
        gap_cnt_r <= '0;
      end
    end
  end

  // Starvation counter for requester 1, saturating at all-ones.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      starve_cnt_r <= '0;
    end else if (!bus.REQ1 || gnt1_r || (state_nxt_s == ST_GRANT1)) begin
      starve_cnt_r <= '0;
    end else if (!(&starve_cnt_r)) begin
      starve_cnt_r <= starve_cnt_r + {{(TMR_W-1){1'b0}}, 1'b1};
    end
  end

  // Lockout masks: set by a timeout, cleared once the hung master drops REQ.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      mask0_r <= 1'b0;
      mask1_r <= 1'b0;
    end else begin
      if (tmo_s && !tmo_id_s) begin
        mask0_r <= 1'b1;
      end else if (!bus.REQ0) begin
        mask0_r <= 1'b0;
      end
      if (tmo_s && tmo_id_s) begin
        mask1_r <= 1'b1;
      end else if (!bus.REQ1) begin
        mask1_r <= 1'b0;
      end
    end
  end

  // Flash-side SPI follows the grantee with no added latency; idle bus parks high/high/low.
  assign bus.nCS   = gnt0_r ? bus.nCS0  : (gnt1_r ? bus.nCS1  : 1'b1);
  assign bus.CLK   = gnt0_r ? bus.CLK0  : (gnt1_r ? bus.CLK1  : 1'b1);
  assign bus.MOSI  = gnt0_r ? bus.MOSI0 : (gnt1_r ? bus.MOSI1 : 1'b0);
  assign bus.MISO0 = gnt0_r & bus.MISO;
  assign bus.MISO1 = gnt1_r & bus.MISO;

  assign bus.GNT0        = gnt0_r;
  assign bus.GNT1        = gnt1_r;
  assign bus.BUSY        = busy_r;
  assign bus.TIMEOUT_ERR = tmo_r;
  assign bus.ERR_ID      = err_id_r;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter with CS_GAP=4, STARVE_LIMIT=16, TIMEOUT_CYC=100.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (or a few ns after an input change for the pass-through paths).
module tb_spi_flash_arbiter;

  logic MCLK;
  logic nRESET;
  int   checks;
  int   passed;

  spi_flash_arbiter_if bus ();

  spi_flash_arbiter #(
    .CS_GAP       (4),
    .STARVE_LIMIT (16),
    .TMR_W        (20),
    .TIMEOUT_CYC  (100)
  ) dut (
    .MCLK   (MCLK),
    .nRESET (nRESET),
    .bus    (bus)
  );

  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  task automatic idle_inputs();
    bus.REQ0  = 1'b0;
    bus.REQ1  = 1'b0;
    bus.nCS0  = 1'b1;
    bus.nCS1  = 1'b1;
    bus.CLK0  = 1'b1;
    bus.CLK1  = 1'b1;
    bus.MOSI0 = 1'b0;
    bus.MOSI1 = 1'b0;
    bus.MISO  = 1'b0;
  endtask

  // Reset released on a falling edge, so the next rising edge is edge 1.
  task automatic do_reset();
    nRESET = 1'b0;
    idle_inputs();
    repeat (2) @(negedge MCLK);
    nRESET = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    nRESET = 1'b0;
    idle_inputs();
    bus.MISO = 1'b1;
    @(negedge MCLK);
    got = {bus.GNT0, bus.GNT1, bus.BUSY, bus.TIMEOUT_ERR, bus.ERR_ID,
           bus.nCS, bus.CLK, bus.MOSI, bus.MISO0, bus.MISO1};
    checks++;
    if (got !== 10'b00000_110_00) $display("FAIL reset_outputs: got %b expected %b", got, 10'b0000011000);
    else passed++;
  endtask

  task automatic test_passthrough();
    logic [2:0] vec;
    logic [2:0] got;
    do_reset();
    bus.REQ0 = 1'b1; bus.nCS0 = 1'b0; bus.CLK0 = 1'b0; bus.MOSI0 = 1'b1; bus.MISO = 1'b1;
    #1;
    got = {bus.nCS, bus.CLK, bus.MOSI};
    checks++;
    if (got !== 3'b110) $display("FAIL idle_bus_parked: got %b expected %b", got, 3'b110);
    else passed++;
    @(negedge MCLK);
    got = {bus.GNT0, bus.GNT1, bus.BUSY};
    checks++;
    if (got !== 3'b101) $display("FAIL grant0_latency: got %b expected %b", got, 3'b101);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      vec = 3'(i * 3 + 1);
      bus.nCS0 = vec[2]; bus.CLK0 = vec[1]; bus.MOSI0 = vec[0];
      #1;
      got = {bus.nCS, bus.CLK, bus.MOSI};
      checks++;
      if (got !== vec) $display("FAIL passthrough_%0d: got %b expected %b", i, got, vec);
      else passed++;
    end
    checks++;
    if ({bus.MISO0, bus.MISO1} !== 2'b10) $display("FAIL miso_route: got %b expected %b", {bus.MISO0, bus.MISO1}, 2'b10);
    else passed++;
    bus.MISO = 1'b0;
    #1;
    checks++;
    if (bus.MISO0 !== 1'b0) $display("FAIL miso_follow: got %b expected %b", bus.MISO0, 1'b0);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_priority_gap();
    logic [2:0] exp;
    logic [2:0] got;
    do_reset();
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
    @(negedge MCLK);
    got = {bus.GNT0, bus.GNT1, bus.BUSY};
    checks++;
    if (got !== 3'b101) $display("FAIL simultaneous_req: got %b expected %b", got, 3'b101);
    else passed++;
    @(negedge MCLK);
    bus.REQ0 = 1'b0;
    for (int c = 3; c <= 8; c++) begin
      @(negedge MCLK);
      if (c <= 6)      exp = 3'b001;
      else if (c == 7) exp = 3'b000;
      else             exp = 3'b011;
      got = {bus.GNT0, bus.GNT1, bus.BUSY};
      checks++;
      if (got !== exp || bus.nCS !== 1'b1) $display("FAIL gap_edge%0d: got %b ncs %b expected %b ncs 1", c, got, bus.nCS, exp);
      else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    int   cnt0;
    int   g1_cycle;
    logic prev_g0;
    do_reset();
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
    cnt0 = 0; g1_cycle = 0; prev_g0 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge MCLK);
      if (g1_cycle == 0) begin
        if (bus.GNT1 === 1'b1) begin
          g1_cycle = c;
        end else if (bus.GNT0 === 1'b1 && !prev_g0) begin
          cnt0++;
          bus.REQ0 = 1'b0;
        end else if (bus.REQ0 == 1'b0) begin
          bus.REQ0 = 1'b1;
        end
        prev_g0 = bus.GNT0;
      end
    end
    checks++;
    if (g1_cycle != 19) $display("FAIL starve_grant_cycle: got %0d expected %0d", g1_cycle, 19);
    else passed++;
    checks++;
    if (cnt0 != 3) $display("FAIL starve_req0_grants: got %0d expected %0d", cnt0, 3);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_timeout();
    int hi_cnt;
    int err_cnt;
    logic [2:0] got;
    do_reset();
    bus.REQ1 = 1'b1; bus.nCS1 = 1'b0;
    hi_cnt = 0; err_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge MCLK);
      if (bus.GNT1 === 1'b1) hi_cnt++;
      if (bus.TIMEOUT_ERR !== 1'b0) err_cnt++;
    end
    checks++;
    if (hi_cnt != 100 || err_cnt != 0) $display("FAIL wd_grant_len: got %0d/%0d expected 100/0", hi_cnt, err_cnt);
    else passed++;
    @(negedge MCLK);
    got = {bus.GNT1, bus.TIMEOUT_ERR, bus.ERR_ID};
    checks++;
    if (got !== 3'b011) $display("FAIL wd_fire: got %b expected %b", got, 3'b011);
    else passed++;
    @(negedge MCLK);
    checks++;
    if (bus.TIMEOUT_ERR !== 1'b0) $display("FAIL wd_pulse_width: got %b expected %b", bus.TIMEOUT_ERR, 1'b0);
    else passed++;
    hi_cnt = 0;
    repeat (18) begin
      @(negedge MCLK);
      if (bus.GNT1 !== 1'b0) hi_cnt++;
    end
    checks++;
    if (hi_cnt != 0) $display("FAIL wd_mask_hold: got %0d expected %0d", hi_cnt, 0);
    else passed++;
    bus.REQ1 = 1'b0; bus.nCS1 = 1'b1;
    @(negedge MCLK);
    bus.REQ1 = 1'b1;
    @(negedge MCLK);
    got = {bus.GNT1, bus.TIMEOUT_ERR, bus.ERR_ID};
    checks++;
    if (got !== 3'b101) $display("FAIL wd_regrant: got %b expected %b", got, 3'b101);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_release_vs_timeout();
    logic [2:0] got;
    do_reset();
    bus.REQ0 = 1'b1; bus.nCS0 = 1'b0;
    repeat (99) @(negedge MCLK);
    bus.REQ0 = 1'b0; bus.nCS0 = 1'b1;
    @(negedge MCLK);
    got = {bus.GNT0, bus.TIMEOUT_ERR, bus.BUSY};
    checks++;
    if (got !== 3'b001) $display("FAIL release_beats_wd: got %b expected %b", got, 3'b001);
    else passed++;
    bus.REQ0 = 1'b1;
    repeat (5) @(negedge MCLK);
    checks++;
    if (bus.GNT0 !== 1'b1) $display("FAIL release_no_mask: got %b expected %b", bus.GNT0, 1'b1);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_hold();
    int held;
    do_reset();
    bus.REQ0 = 1'b1; bus.nCS0 = 1'b0;
    @(negedge MCLK);
    bus.REQ0 = 1'b0;
    held = 0;
    repeat (3) begin
      @(negedge MCLK);
      if (bus.GNT0 === 1'b1) held++;
    end
    checks++;
    if (held != 3) $display("FAIL hold_while_cs_low: got %0d expected %0d", held, 3);
    else passed++;
    bus.nCS0 = 1'b1;
    @(negedge MCLK);
    checks++;
    if ({bus.GNT0, bus.BUSY} !== 2'b01) $display("FAIL hold_release: got %b expected %b", {bus.GNT0, bus.BUSY}, 2'b01);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_reset_mid_grant();
    logic [4:0] got;
    do_reset();
    bus.REQ0 = 1'b1; bus.nCS0 = 1'b0; bus.CLK0 = 1'b0; bus.MOSI0 = 1'b1;
    @(negedge MCLK);
    got = {bus.GNT0, bus.nCS, bus.CLK, bus.MOSI, bus.BUSY};
    checks++;
    if (got !== 5'b10011) $display("FAIL pre_reset_grant: got %b expected %b", got, 5'b10011);
    else passed++;
    #2;
    nRESET = 1'b0;
    #1;
    got = {bus.GNT0, bus.nCS, bus.CLK, bus.MOSI, bus.BUSY};
    checks++;
    if (got !== 5'b01100) $display("FAIL async_reset: got %b expected %b", got, 5'b01100);
    else passed++;
    @(negedge MCLK);
    nRESET = 1'b1;
    #1;
    checks++;
    if (bus.GNT0 !== 1'b0) $display("FAIL post_reset_idle: got %b expected %b", bus.GNT0, 1'b0);
    else passed++;
    @(negedge MCLK);
    checks++;
    if (bus.GNT0 !== 1'b1) $display("FAIL post_reset_regrant: got %b expected %b", bus.GNT0, 1'b1);
    else passed++;
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    nRESET = 1'b0;
    idle_inputs();
    test_reset();
    test_passthrough();
    test_priority_gap();
    test_starvation();
    test_timeout();
    test_release_vs_timeout();
    test_hold();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
